alu_seq: RTL and testbench

Parametrised, handshaked ALU that succeeds the combinational 32-bit `alu`. It keeps the same operand and opcode style (`A`, `B`, `opALU`, `ALU_Out`, `CarryOut`) and adds:
- generic `WIDTH`;
- registered results with a valid/ready handshake;
- Zero, Overflow and error flags;
- iterative multi-cycle unsigned multiply and divide producing a high/remainder word.

It sits between the datapath register read stage and writeback, or can be used standalone under a bench.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_muldiv_iter.sv | 77 +++++++
 rtl/alu_seq.sv | 129 ++++++++++++
 tb/tb_alu_seq.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
// Imported by the ALU top and by any bench that drives it.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aluStateT;

    // Multiply and divide take the iterative path; everything else finishes in one edge
    function automatic logic isIterOp(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU: operands and opcode in,
// registered result and flags out, with a valid/ready request handshake.
interface alu_seq_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       opALU;
    logic             out_valid;
    logic [WIDTH-1:0] ALU_Out;
    logic [WIDTH-1:0] Hi_Out;
    logic             CarryOut;
    logic             Overflow;
    logic             Zero;
    logic             Err;

    modport master (
        output in_valid, A, B, opALU,
        input  in_ready, out_valid, ALU_Out, Hi_Out, CarryOut, Overflow, Zero, Err
    );

    modport slave (
        input  in_valid, A, B, opALU,
        output in_ready, out_valid, ALU_Out, Hi_Out, CarryOut, Overflow, Zero, Err
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// lo/hi present the values after the current iteration, so they are final while done is high.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             running;
    logic             divMode;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   shifted;
    logic             borrow;
    logic [WIDTH-1:0] hiNext;
    logic [WIDTH-1:0] loNext;

    // hi holds the partial product / remainder, lo the multiplier / quotient being shifted
    always_comb begin
        addSum  = {1'b0, hiReg} + (loReg[0] ? {1'b0, operand} : '0);
        shifted = {hiReg, loReg[WIDTH-1]};
        borrow  = shifted < {1'b0, operand};
        hiNext  = '0;
        loNext  = '0;
        if (divMode) begin
            hiNext = borrow ? shifted[WIDTH-1:0] : (shifted[WIDTH-1:0] - operand);
            loNext = {loReg[WIDTH-2:0], ~borrow};
        end else begin
            hiNext = addSum[WIDTH:1];
            loNext = {addSum[0], loReg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            divMode <= 1'b0;
            count   <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            operand <= '0;
        end else if (start) begin
            running <= 1'b1;
            divMode <= is_div;
            count   <= '0;
            hiReg   <= '0;
            loReg   <= a;
            operand <= b;
        end else if (running) begin
            hiReg <= hiNext;
            loReg <= loNext;
            count <= count + CW'(1);
            if (count == LAST) begin
                running <= 1'b0;
            end
        end
    end

    assign done = running && (count == LAST);
    assign lo   = loNext;
    assign hi   = hiNext;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-edge logic/arithmetic ops plus iterative MULU/DIVU,
// with registered result, high word and Zero/Carry/Overflow/Err flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);

    aluStateT         state;
    aluStateT         stateNext;
    logic             readyInt;
    logic             validInt;
    logic             accept;
    logic             startIter;
    logic             loadSingle;
    logic             loadIter;
    logic             iterDone;
    logic [WIDTH-1:0] iterLo;
    logic [WIDTH-1:0] iterHi;
    logic             isSub;
    logic [WIDTH:0]   addSum;
    logic [WIDTH-1:0] singleRes;
    logic             singleCarry;
    logic             singleOvf;
    logic             singleErr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = isIterOp(bus.opALU) ? BUSY : DONE;
            BUSY: if (iterDone) stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Ready is masked by reset so nothing can be accepted while the block is being cleared
    always_comb begin
        readyInt   = (state == IDLE) && !reset;
        validInt   = (state == DONE);
        accept     = bus.in_valid && readyInt;
        startIter  = accept && isIterOp(bus.opALU);
        loadSingle = accept && !isIterOp(bus.opALU);
        loadIter   = (state == BUSY) && iterDone;
    end

    assign bus.in_ready  = readyInt;
    assign bus.out_valid = validInt;

    // ADD and SUB share one adder; SUB is A + ~B + 1 so the carry reads as "no borrow"
    always_comb begin
        isSub       = (bus.opALU == OP_SUB);
        addSum      = {1'b0, bus.A} + {1'b0, (isSub ? ~bus.B : bus.B)} + {{WIDTH{1'b0}}, isSub};
        singleRes   = '0;
        singleCarry = 1'b0;
        singleOvf   = 1'b0;
        singleErr   = 1'b0;
        case (bus.opALU)
            OP_AND: singleRes = bus.A & bus.B;
            OP_OR:  singleRes = bus.A | bus.B;
            OP_NOR: singleRes = ~(bus.A | bus.B);
            OP_SLT: singleRes = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_ADD: begin
                singleRes   = addSum[WIDTH-1:0];
                singleCarry = addSum[WIDTH];
                singleOvf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                              (addSum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                singleRes   = addSum[WIDTH-1:0];
                singleCarry = addSum[WIDTH];
                singleOvf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                              (addSum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_MULU, OP_DIVU: singleErr = 1'b0;
            default: singleErr = 1'b1;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) iterUnit (
        .clk    (clk),
        .reset  (reset),
        .start  (startIter),
        .is_div (bus.opALU == OP_DIVU),
        .a      (bus.A),
        .b      (bus.B),
        .done   (iterDone),
        .lo     (iterLo),
        .hi     (iterHi)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ALU_Out  <= '0;
            bus.Hi_Out   <= '0;
            bus.CarryOut <= 1'b0;
            bus.Overflow <= 1'b0;
            bus.Zero     <= 1'b1;
            bus.Err      <= 1'b0;
        end else if (loadSingle) begin
            bus.ALU_Out  <= singleRes;
            bus.Hi_Out   <= '0;
            bus.CarryOut <= singleCarry;
            bus.Overflow <= singleOvf;
            bus.Zero     <= (singleRes == '0);
            bus.Err      <= singleErr;
        end else if (loadIter) begin
            bus.ALU_Out  <= iterLo;
            bus.Hi_Out   <= iterHi;
            bus.CarryOut <= 1'b0;
            bus.Overflow <= 1'b0;
            bus.Zero     <= (iterLo == '0);
            bus.Err      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH = 32: directed operations checked against an
// arithmetic reference model every cycle, plus literal expectations per scenario.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic        err;
        int          due;
    } expT;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(WIDTH)) bus();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    expT pending[$];
    expT lastExp;
    int  cyc = 0;
    int  busyStart = 1;
    int  busyUntil = 0;
    int  testsRun = 0;
    int  testsFailed = 0;
    int  acceptEdge = 0;
    int  outEdge = 0;
    int  divEdge = 0;

    function automatic expT resetExp();
        expT e;
        e.lo = '0; e.hi = '0; e.carry = 1'b0; e.ovf = 1'b0;
        e.zero = 1'b1; e.err = 1'b0; e.due = 0;
        return e;
    endfunction

    // Reference results from plain integer arithmetic on the operand values
    function automatic expT model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        expT e;
        longint sa, sb, s;
        longint unsigned p;
        e = resetExp();
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'b0000: e.lo = a & b;
            4'b0001: e.lo = a | b;
            4'b1100: e.lo = ~(a | b);
            4'b0010: begin
                p = 64'(a) + 64'(b);
                e.lo = p[31:0];
                e.carry = p[32];
                s = sa + sb;
                e.ovf = (s > SMAX) || (s < SMIN);
            end
            4'b0110: begin
                e.lo = a - b;
                e.carry = (a >= b);
                s = sa - sb;
                e.ovf = (s > SMAX) || (s < SMIN);
            end
            4'b0111: e.lo = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: begin
                p = 64'(a) * 64'(b);
                e.lo = p[31:0];
                e.hi = p[63:32];
            end
            4'b1001: begin
                if (b == 0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.lo == 0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; holds the request until the DUT shows ready
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit keepValid);
        expT e;
        int n;
        bus.opALU = op;
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_seen", bus.in_ready, 1);
        e = model(op, a, b);
        acceptEdge = cyc + 1;
        e.due = acceptEdge + (((op == OP_MULU) || (op == OP_DIVU)) ? WIDTH : 0);
        pending.push_back(e);
        busyStart = acceptEdge;
        busyUntil = e.due;
        @(negedge clk);
        if (!keepValid) bus.in_valid = 1'b0;
    endtask

    task automatic waitResult();
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("out_valid_seen", bus.out_valid, 1);
        outEdge = cyc;
    endtask

    // Every cycle: ready window, valid pulse and held outputs against the model
    initial begin : compareProc
        logic expValid;
        logic expReady;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            expValid = 1'b0;
            if (!reset && pending.size() > 0 && pending[0].due == cyc) begin
                lastExp = pending.pop_front();
                expValid = 1'b1;
            end
            expReady = !reset && !(cyc >= busyStart && cyc <= busyUntil);
            checkOutput("in_ready", bus.in_ready, expReady);
            checkOutput("out_valid", bus.out_valid, expValid);
            checkOutput("ALU_Out", bus.ALU_Out, lastExp.lo);
            checkOutput("Hi_Out", bus.Hi_Out, lastExp.hi);
            checkOutput("CarryOut", bus.CarryOut, lastExp.carry);
            checkOutput("Overflow", bus.Overflow, lastExp.ovf);
            checkOutput("Zero", bus.Zero, lastExp.zero);
            checkOutput("Err", bus.Err, lastExp.err);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        lastExp = resetExp();
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.opALU = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_por", bus.in_ready, 1);

        applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        waitResult();
        checkOutput("add_wrap_edge", outEdge - acceptEdge, 0);
        checkOutput("add_wrap_out", bus.ALU_Out, 0);
        checkOutput("add_wrap_carry", bus.CarryOut, 1);
        checkOutput("add_wrap_zero", bus.Zero, 1);
        checkOutput("add_wrap_ovf", bus.Overflow, 0);
        @(negedge clk);
        checkOutput("add_wrap_pulse", bus.out_valid, 0);

        applyStimulus(OP_SUB, 32'd5, 32'd7, 1'b0);
        waitResult();
        checkOutput("sub_neg_out", bus.ALU_Out, 32'hFFFF_FFFE);
        checkOutput("sub_neg_carry", bus.CarryOut, 0);
        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
        waitResult();
        checkOutput("add_ovf", bus.Overflow, 1);
        checkOutput("add_ovf_out", bus.ALU_Out, 32'h8000_0000);
        applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        waitResult();
        checkOutput("slt_neg", bus.ALU_Out, 1);
        applyStimulus(OP_SUB, 32'h8000_0000, 32'd1, 1'b0);
        waitResult();
        checkOutput("sub_ovf", bus.Overflow, 1);
        checkOutput("sub_ovf_carry", bus.CarryOut, 1);
        applyStimulus(OP_NOR, 32'h0F0F_0000, 32'h0000_00FF, 1'b0);
        waitResult();
        checkOutput("nor_out", bus.ALU_Out, 32'hF0F0_FF00);
        applyStimulus(OP_OR, 32'h1200_0000, 32'h0000_0034, 1'b0);
        waitResult();

        applyStimulus(OP_MULU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        waitResult();
        checkOutput("mulu_edge", outEdge - acceptEdge, 32);
        checkOutput("mulu_lo", bus.ALU_Out, 32'hFFFF_FFFE);
        checkOutput("mulu_hi", bus.Hi_Out, 1);
        applyStimulus(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        waitResult();
        checkOutput("mulu_max_hi", bus.Hi_Out, 32'hFFFF_FFFE);

        applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b0);
        waitResult();
        checkOutput("divu_quot", bus.ALU_Out, 14);
        checkOutput("divu_rem", bus.Hi_Out, 2);
        applyStimulus(OP_DIVU, 32'd100, 32'd0, 1'b0);
        waitResult();
        checkOutput("divu0_quot", bus.ALU_Out, 32'hFFFF_FFFF);
        checkOutput("divu0_rem", bus.Hi_Out, 100);
        checkOutput("divu0_err", bus.Err, 0);

        applyStimulus(OP_MULU, 32'h1234_5678, 32'd9, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        pending.delete();
        lastExp = resetExp();
        busyStart = 1;
        busyUntil = 0;
        @(negedge clk);
        checkOutput("rst_out", bus.ALU_Out, 0);
        checkOutput("rst_hi", bus.Hi_Out, 0);
        checkOutput("rst_zero", bus.Zero, 1);
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_ready_low", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready_high", bus.in_ready, 1);
        repeat (25) @(negedge clk);
        applyStimulus(OP_ADD, 32'd3, 32'd4, 1'b0);
        waitResult();
        checkOutput("add_after_rst", bus.ALU_Out, 7);

        applyStimulus(OP_DIVU, 32'd1000, 32'd10, 1'b1);
        divEdge = acceptEdge;
        applyStimulus(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
        checkOutput("queued_accept_edge", acceptEdge, divEdge + 34);
        waitResult();
        checkOutput("queued_and", bus.ALU_Out, 32'h00F0_1200);

        applyStimulus(4'b1111, 32'd5, 32'd6, 1'b0);
        waitResult();
        checkOutput("undef_out", bus.ALU_Out, 0);
        checkOutput("undef_err", bus.Err, 1);
        checkOutput("undef_zero", bus.Zero, 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
